// File: rtl/seg_display_pkg.sv
// Shared constants for the 4-digit multiplexed display: segment patterns
// ({g,f,e,d,c,b,a}, active-low) and the scan-slot digit encodings.
package seg_display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;

  typedef enum logic [1:0] {
    IDX_THOUSANDTHS = 2'd0,
    IDX_HUNDRETHS   = 2'd1,
    IDX_TENTHS      = 2'd2,
    IDX_ONES        = 2'd3
  } digit_idx_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes blank.
module bcd_to_seg7
  import seg_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed scanner for a 4-digit X.XXX display. A whole frame is
// sampled at once at the frame boundary so the four digits always agree.
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ones,
  input  logic [3:0] tenths,
  input  logic [3:0] hundreths,
  input  logic [3:0] thousandths,
  input  logic       hold,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_e    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          slotEnd;
  logic [3:0]    digit;
  logic [6:0]    digitSeg;

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (digitSeg)
  );

  always_comb begin
    slotEnd = (cnt_q == CNT_LAST);
    cnt_d   = slotEnd ? '0 : cnt_q + CW'(1);
    idx_d   = slotEnd ? digit_idx_e'(idx_q + 2'd1) : idx_q;
    snap_d  = snap_q;
    // Only the last cycle of the ones slot may resample, and never while frozen.
    if (slotEnd && (idx_q == IDX_ONES) && !hold) begin
      snap_d = {ones, tenths, hundreths, thousandths};
    end

    digit = snap_q[3:0];
    case (idx_q)
      IDX_THOUSANDTHS: digit = snap_q[3:0];
      IDX_HUNDRETHS:   digit = snap_q[7:4];
      IDX_TENTHS:      digit = snap_q[11:8];
      IDX_ONES:        digit = snap_q[15:12];
      default:         digit = snap_q[3:0];
    endcase

    // First cycle of each slot blanks the anodes to suppress ghosting.
    seg_d = digitSeg;
    an_d  = (cnt_q == '0) ? 4'hF : ~(4'b0001 << idx_q);
    dp_d  = !((idx_q == IDX_ONES) && (cnt_q != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= IDX_THOUSANDTHS;
      snap_q <= 16'h0000;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      an_q   <= 4'hF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed self-checking bench for seg_display_scan with a short refresh divider.
module tb_seg_display_scan;

  localparam int DIV = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ones = 4'd0, tenths = 4'd0, hundreths = 4'd0, thousandths = 4'd0;
  logic       hold = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checkCount = 0;
  int passCount  = 0;

  logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] capSeg [FRAME];
  logic [3:0] capAn  [FRAME];
  logic       capDp  [FRAME];

  seg_display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ones        (ones),
    .tenths      (tenths),
    .hundreths   (hundreths),
    .thousandths (thousandths),
    .hold        (hold),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  always #5 clk = ~clk;

  task automatic setDigits(input logic [15:0] v);
    {ones, tenths, hundreths, thousandths} = v;
  endtask

  // Records outputs for a run of slots, sampled 1 time unit after each edge.
  task automatic captureSlots(input int firstSlot, input int nSlots);
    for (int i = firstSlot * DIV; i < (firstSlot + nSlots) * DIV; i++) begin
      @(posedge clk);
      #1;
      capSeg[i] = seg;
      capAn[i]  = an;
      capDp[i]  = dp;
    end
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if (seg !== 7'h7F) $display("[TB] FAIL reset_seg got %h expected 7f", seg);
    else passCount++;
    checkCount++;
    if (dp !== 1'b1) $display("[TB] FAIL reset_dp got %b expected 1", dp);
    else passCount++;
    checkCount++;
    if (an !== 4'hF) $display("[TB] FAIL reset_an got %b expected 1111", an);
    else passCount++;
    hold = 1'b0;
  endtask

  task automatic test_first_frame();
    logic [15:0] expVal [2];
    expVal[0] = 16'h0000;
    expVal[1] = 16'h1234;
    setDigits(16'h1234);
    releaseReset();
    for (int f = 0; f < 2; f++) begin
      captureSlots(0, 4);
      for (int i = 0; i < FRAME; i++) begin
        int s = i / DIV;
        int c = i % DIV;
        logic [15:0] v = expVal[f];
        logic [3:0] eAn = (c == 0) ? 4'hF : ~(4'b0001 << s);
        logic eDp = (s == 3 && c != 0) ? 1'b0 : 1'b1;
        logic [6:0] eSeg = segTable[v[s*4 +: 4]];
        checkCount++;
        if (capAn[i] !== eAn) $display("[TB] FAIL first_frame_an f%0d s%0d c%0d got %b expected %b", f, s, c, capAn[i], eAn);
        else passCount++;
        checkCount++;
        if (capDp[i] !== eDp) $display("[TB] FAIL first_frame_dp f%0d s%0d c%0d got %b expected %b", f, s, c, capDp[i], eDp);
        else passCount++;
        checkCount++;
        if (capSeg[i] !== eSeg) $display("[TB] FAIL first_frame_seg f%0d s%0d c%0d got %h expected %h", f, s, c, capSeg[i], eSeg);
        else passCount++;
      end
    end
  endtask

  task automatic test_bad_code();
    logic [15:0] expVal [2];
    expVal[0] = 16'h1234;
    expVal[1] = 16'h123A;
    setDigits(16'h123A);
    for (int f = 0; f < 2; f++) begin
      captureSlots(0, 4);
      for (int i = 0; i < FRAME; i++) begin
        int s = i / DIV;
        int c = i % DIV;
        logic [15:0] v = expVal[f];
        logic [6:0] eSeg = segTable[v[s*4 +: 4]];
        logic [3:0] eAn = (c == 0) ? 4'hF : ~(4'b0001 << s);
        checkCount++;
        if (capSeg[i] !== eSeg) $display("[TB] FAIL bad_code_seg f%0d s%0d c%0d got %h expected %h", f, s, c, capSeg[i], eSeg);
        else passCount++;
        checkCount++;
        if (capAn[i] !== eAn) $display("[TB] FAIL bad_code_an f%0d s%0d c%0d got %b expected %b", f, s, c, capAn[i], eAn);
        else passCount++;
      end
    end
  endtask

  task automatic test_mid_frame_change();
    logic [15:0] expVal [3];
    expVal[0] = 16'h123A;
    expVal[1] = 16'h1234;
    expVal[2] = 16'h5678;
    setDigits(16'h1234);
    for (int f = 0; f < 3; f++) begin
      if (f == 1) begin
        captureSlots(0, 1);
        setDigits(16'h5678);
        captureSlots(1, 3);
      end else begin
        captureSlots(0, 4);
      end
      for (int i = 0; i < FRAME; i++) begin
        int s = i / DIV;
        int c = i % DIV;
        logic [15:0] v = expVal[f];
        logic [6:0] eSeg = segTable[v[s*4 +: 4]];
        logic eDp = (s == 3 && c != 0) ? 1'b0 : 1'b1;
        checkCount++;
        if (capSeg[i] !== eSeg) $display("[TB] FAIL mid_change_seg f%0d s%0d c%0d got %h expected %h", f, s, c, capSeg[i], eSeg);
        else passCount++;
        checkCount++;
        if (capDp[i] !== eDp) $display("[TB] FAIL mid_change_dp f%0d s%0d c%0d got %b expected %b", f, s, c, capDp[i], eDp);
        else passCount++;
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] expVal [6];
    expVal = '{16'h5678, 16'h5678, 16'h5678, 16'h5678, 16'h5678, 16'h9999};
    for (int f = 0; f < 6; f++) begin
      if (f == 0) begin
        captureSlots(0, 1);
        hold = 1'b1;
        setDigits(16'h9999);
        captureSlots(1, 3);
      end else begin
        if (f == 4) hold = 1'b0;
        captureSlots(0, 4);
      end
      for (int i = 0; i < FRAME; i++) begin
        int s = i / DIV;
        int c = i % DIV;
        logic [15:0] v = expVal[f];
        logic [6:0] eSeg = segTable[v[s*4 +: 4]];
        checkCount++;
        if (capSeg[i] !== eSeg) $display("[TB] FAIL hold_seg f%0d s%0d c%0d got %h expected %h", f, s, c, capSeg[i], eSeg);
        else passCount++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] expVal [2];
    expVal[0] = 16'h0000;
    expVal[1] = 16'h9999;
    captureSlots(0, 2);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    hold  = 1'b1;
    #1;
    checkCount++;
    if (seg !== 7'h7F) $display("[TB] FAIL async_reset_seg got %h expected 7f", seg);
    else passCount++;
    checkCount++;
    if (dp !== 1'b1) $display("[TB] FAIL async_reset_dp got %b expected 1", dp);
    else passCount++;
    checkCount++;
    if (an !== 4'hF) $display("[TB] FAIL async_reset_an got %b expected 1111", an);
    else passCount++;
    repeat (2) @(posedge clk);
    hold = 1'b0;
    releaseReset();
    for (int f = 0; f < 2; f++) begin
      captureSlots(0, 4);
      for (int i = 0; i < FRAME; i++) begin
        int s = i / DIV;
        int c = i % DIV;
        logic [15:0] v = expVal[f];
        logic [3:0] eAn = (c == 0) ? 4'hF : ~(4'b0001 << s);
        logic [6:0] eSeg = segTable[v[s*4 +: 4]];
        checkCount++;
        if (capAn[i] !== eAn) $display("[TB] FAIL restart_an f%0d s%0d c%0d got %b expected %b", f, s, c, capAn[i], eAn);
        else passCount++;
        checkCount++;
        if (capSeg[i] !== eSeg) $display("[TB] FAIL restart_seg f%0d s%0d c%0d got %h expected %h", f, s, c, capSeg[i], eSeg);
        else passCount++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_bad_code();
    test_mid_frame_change();
    test_hold();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 50000, clocks per digit slot; legal range is 2 or more.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; it SHALL be asynchronous and active-low.
REQ-004 ones  input  4  BCD seconds digit from the BCD counter.
REQ-005 tenths  input  4  BCD tenths digit.
REQ-006 hundreths  input  4  BCD hundredths digit.
REQ-007 thousandths  input  4  BCD thousandths digit.
REQ-008 hold  input  1  active-high; when 1 the displayed value SHALL be frozen.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 dp  output  1  decimal point, active-low, registered.
REQ-011 an  output  4  digit anodes, active-low, registered; an[3]=ones … an[0]=thousandths.

Function
REQ-012 The prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0 after REFRESH_DIV-1.
REQ-013 The digit index idx (2 bits) SHALL increment, wrapping 3->0, on each cycle where cnt==REFRESH_DIV-1.
REQ-014 Index-to-digit mapping SHALL be: 0=thousandths, 1=hundreths, 2=tenths, 3=ones.
REQ-015 The 16-bit snapshot register SHALL load {ones,tenths,hundreths,thousandths} on cycles where cnt==REFRESH_DIV-1, idx==3 and hold==0. This is the frame boundary.
REQ-016 The snapshot register SHALL hold its value at all other times, so all four digits of one frame come from the same sample.
REQ-017 When hold rises mid-frame, the current frame SHALL finish unchanged and no further loads SHALL occur while hold==1.
REQ-018 When hold falls, the next frame boundary SHALL load new data.
REQ-019 seg, dp and an SHALL be registered and computed each cycle from the current cnt, idx and snapshot, giving one clock of latency.
REQ-020 an SHALL be 4'b1111 (blanking) when cnt==0; otherwise an SHALL be the one-cold vector of idx, with only an[idx]=0.
REQ-021 seg SHALL decode the selected snapshot digit: BCD 0-9 to the standard 7-segment patterns, active-low.
REQ-022 Codes 10-15 SHALL produce all segments off (7'h7F).
REQ-023 dp SHALL be 0 (lit) only when idx==3 and an is not blanking; otherwise dp SHALL be 1. This displays the format X.XXX.
REQ-024 Input changes between frame boundaries SHALL have no effect on the outputs.

Reset
REQ-025 While rst_n==0 the module SHALL immediately force cnt=0, idx=0, snapshot=16'h0000, seg=7'h7F, dp=1 and an=4'hF.
REQ-026 Reset asserted mid-frame SHALL abort the frame. After release, scanning SHALL restart at idx 0 showing snapshot 0000 until the first frame boundary.
REQ-027 hold SHALL have no effect during reset.

Structure
REQ-028 A shared package seg_display_pkg SHALL hold SEG_OFF=7'h7F, the ten digit segment constants, and the digit-index encodings.
REQ-029 The design SHALL contain exactly one sub-module, bcd_to_seg7: combinational 4-bit BCD in, 7-bit active-low segments out, using the package constants.
REQ-030 The top level SHALL contain the prescaler, idx, snapshot and output registers only.

Verification (REFRESH_DIV=4)
REQ-031 Reset release with inputs 1,2,3,4 and hold=0: the first 4 slots SHALL show 0 on every digit, and the next frame SHALL show an 1110->"4", 1101->"3", 1011->"2", 0111->"1" with dp=0.
REQ-032 In every slot, the first output cycle after the slot starts SHALL have an=4'hF.
REQ-033 Input digit 0xA: seg SHALL be 7'h7F in that digit's slot.
REQ-034 Change inputs 1234->5678 at idx 1: the remainder of the frame SHALL still show 1234, and the next frame SHALL show 5678.
REQ-035 Assert hold, then change inputs to 9999 across 3 frames: the display SHALL stay at its prior value. Deassert hold: the next frame SHALL show 9999.
REQ-036 Pulse rst_n low mid-slot at idx 2: outputs SHALL go to 7F/1/F asynchronously, and idx SHALL restart at 0.
